// File: rtl/inv_mix_cols_iter.sv
// Iterative AES InvMixColumns: one column per clock through a single shared
// column transform, with valid/ready handshakes on input and output.
module inv_mix_cols_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] din,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] dout,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    col;
  logic [127:0]  work;
  logic [31:0]   col_in, col_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Products by 09/0b/0d/0e built from b, 2b, 4b and 8b.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    logic [7:0] x1, x2, x3;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x1    = xtime(a[i]);
      x2    = xtime(x1);
      x3    = xtime(x2);
      m9[i] = x3 ^ a[i];
      mb[i] = x3 ^ x1 ^ a[i];
      md[i] = x3 ^ x2 ^ a[i];
      me[i] = x3 ^ x2 ^ x1;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    col_in = work[127:96];
    case (col)
      2'd0: col_in = work[127:96];
      2'd1: col_in = work[95:64];
      2'd2: col_in = work[63:32];
      2'd3: col_in = work[31:0];
      default: col_in = work[127:96];
    endcase
  end

  assign col_out = inv_col(col_in);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (col == 2'd3) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: work is a plain register, not a memory, so it is reset to give a defined dout after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      col  <= 2'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work <= din;
          col  <= 2'd0;
        end
        BUSY: begin
          case (col)
            2'd0: work[127:96] <= col_out;
            2'd1: work[95:64]  <= col_out;
            2'd2: work[63:32]  <= col_out;
            2'd3: work[31:0]   <= col_out;
            default: ;
          endcase
          col <= col + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  assign dout = work;

endmodule

// File: tb/tb_inv_mix_cols_iter.sv
// Scoreboard bench for inv_mix_cols_iter: directed FIPS/backpressure/reset
// cases plus a randomized mix_cols round trip against a GF(2^8) matrix model.
module tb_inv_mix_cols_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] dout;
  logic         out_valid;
  logic         out_ready;
  logic         rand_ready;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  inv_mix_cols_iter dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: generic shift-and-add GF(2^8) multiply and matrix product.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mat_mul(input logic [127:0] x, input logic [31:0] row0);
    logic [127:0] y = '0;
    logic [7:0] coef [4];
    for (int k = 0; k < 4; k++) coef[k] = row0[31-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        logic [7:0] acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gf_mul(coef[(k - r + 4) % 4], x[127-8*(4*c+k) -: 8]);
        y[127-8*(4*c+r) -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] x);
    return mat_mul(x, 32'h02030101);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] x);
    return mat_mul(x, 32'h0e0b0d09);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", dout);
      end else begin
        check("dout", dout, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents d until accepted; returns one tick after the acceptance edge.
  task automatic send(input logic [127:0] d, input bit push, input logic [127:0] exp);
    int n = 0;
    in_valid = 1'b1;
    din      = d;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    if (push) exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    din      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called one tick after acceptance with out_ready high.
  task automatic latency_check(input string tag);
    for (int k = 0; k < 5; k++) begin
      check({tag, "_in_ready_low"}, 128'(in_ready), 128'(0));
      check({tag, "_out_valid"}, 128'(out_valid), 128'(k == 4));
      tick();
    end
    check({tag, "_in_ready_back"}, 128'(in_ready), 128'(1));
    check({tag, "_out_valid_gone"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] v, ev, x;
    int n;
    rst        = 1'b1;
    in_valid   = 1'b0;
    din        = '0;
    out_ready  = 1'b0;
    rand_ready = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_dout", dout, 128'h0);
    rst = 1'b0;
    tick();

    // FIPS-197 vectors with timing
    out_ready = 1'b1;
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
         128'hdb135345_f20a225c_01010101_c6c6c6c6);
    latency_check("fips");
    send(128'hd5d5d7d6_4d7ebdf8_00000000_00000000, 1'b1,
         128'hd4d4d4d5_2d26314c_00000000_00000000);
    latency_check("cols01");

    // Backpressure
    out_ready = 1'b0;
    v  = {$urandom, $urandom, $urandom, $urandom};
    ev = inv_mix(v);
    send(v, 1'b1, ev);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_out_valid_rise", 128'(out_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      din      = {$urandom, $urandom, $urandom, $urandom};
      check("bp_dout_hold", dout, ev);
      check("bp_in_ready_low", 128'(in_ready), 128'(0));
      check("bp_out_valid_hold", 128'(out_valid), 128'(1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", 128'(out_valid), 128'(0));
    check("bp_release_in_ready", 128'(in_ready), 128'(1));

    // Asynchronous reset two cycles after acceptance
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_dout", dout, 128'h0);
    check("arst_in_ready", 128'(in_ready), 128'(1));
    tick();
    rst = 1'b0;
    tick();
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
         128'hdb135345_f20a225c_01010101_c6c6c6c6);
    latency_check("post_rst");

    // Randomized round trip with stalls on both sides
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      x = {$urandom, $urandom, $urandom, $urandom};
      send(fwd_mix(x), 1'b1, x);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    check("drain_queue_empty", 128'(exp_q.size()), 128'(0));
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
